// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the DM port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int   DM_WORDS_DEF = 3072;
  localparam logic PORT0        = 1'b0;
  localparam logic PORT1        = 1'b1;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester-side bundle: port 0 (CPU MEM stage) and port 1 (loader/debug).
interface dm_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req_0, req_1;
  logic              we_0, we_1;
  logic              lock_0, lock_1;
  logic [DATA_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic [DATA_W-1:0] pc_0, pc_1;
  logic              gnt_0, gnt_1;
  logic              rvalid_0, rvalid_1;
  logic [DATA_W-1:0] rdata_0, rdata_1;
  logic              err_0, err_1;

  modport master (
    output req_0, req_1, we_0, we_1, lock_0, lock_1,
           addr_0, addr_1, wdata_0, wdata_1, pc_0, pc_1,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, err_0, err_1
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, lock_0, lock_1,
           addr_0, addr_1, wdata_0, wdata_1, pc_0, pc_1,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, err_0, err_1
  );
endinterface

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker: a tie goes to the port that did not own last.
// Purely combinational.
module dm_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       winner_o,
  output logic       any_o
);
  assign any_o    = |req_i;
  assign winner_o = (&req_i) ? ~last_owner_i : req_i[1];
endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory; grant is same-cycle, load data one cycle later.
// Optional address range check enabled by DM_ARB_RANGE_CHECK_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  dm_port_arbiter_if.slave  bus,
  output logic [DATA_W-1:0] dm_add,
  output logic [DATA_W-1:0] dm_data,
  output logic              dm_memW,
  output logic              dm_memR,
  output logic [DATA_W-1:0] dm_pc,
  input  logic [DATA_W-1:0] dm_WB
);
  localparam int                HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [DATA_W-3:0] WORD_LIM = (DATA_W - 2)'(DM_WORDS);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_q;
  logic [1:0]        rvalid_q, err_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        req_v, lock_v, gnt_v;
  logic              rr_win, rr_any, own;
  logic              sel, any_gnt, sel_we, addr_bad, chk_en, rsp;
  logic [DATA_W-1:0] sel_addr, sel_wdata, sel_pc;

  assign req_v  = {bus.req_1, bus.req_0};
  assign lock_v = {bus.lock_1, bus.lock_0};

  dm_arb_rr u_rr (
    .req_i        (req_v),
    .last_owner_i (last_q),
    .winner_o     (rr_win),
    .any_o        (rr_any)
  );

  always_comb begin
    gnt_v   = 2'b00;
    state_d = state_q;
    hold_d  = hold_q;
    own     = (state_q == OWN1);
    case (state_q)
      OWN0, OWN1: begin
        if (req_v[own] && (lock_v[own] || !req_v[~own] || hold_q < HOLD_LIM)) begin
          gnt_v[own] = 1'b1;
          hold_d     = (hold_q == HOLD_LIM) ? HOLD_LIM : hold_q + HOLD_W'(1);
        end else if (lock_v[own]) begin
          // owner holds the lock with no request: keep ownership, other port waits
          hold_d = hold_q;
        end else if (req_v[~own]) begin
          gnt_v[~own] = 1'b1;
          state_d     = own ? OWN0 : OWN1;
          hold_d      = HOLD_W'(1);
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        if (rr_any) begin
          gnt_v[rr_win] = 1'b1;
          state_d       = rr_win ? OWN1 : OWN0;
          hold_d        = HOLD_W'(1);
        end
      end
    endcase
    if (!reset) gnt_v = 2'b00;
  end

`ifdef DM_ARB_RANGE_CHECK_EN
  assign chk_en = 1'b1;
`else
  assign chk_en = 1'b0;
`endif

  assign sel       = gnt_v[1];
  assign any_gnt   = |gnt_v;
  assign sel_addr  = sel ? bus.addr_1  : bus.addr_0;
  assign sel_wdata = sel ? bus.wdata_1 : bus.wdata_0;
  assign sel_pc    = sel ? bus.pc_1    : bus.pc_0;
  assign sel_we    = sel ? bus.we_1    : bus.we_0;
  assign addr_bad  = chk_en && ((sel_addr[1:0] != 2'b00) || (sel_addr[DATA_W-1:2] >= WORD_LIM));

  assign dm_add  = any_gnt ? sel_addr  : '0;
  assign dm_data = any_gnt ? sel_wdata : '0;
  assign dm_pc   = any_gnt ? sel_pc    : '0;
  assign dm_memW = any_gnt &&  sel_we && !addr_bad;
  assign dm_memR = any_gnt && !sel_we && !addr_bad;
  // a rejected access answers like a load so the requester is never left waiting
  assign rsp     = any_gnt && (!sel_we || addr_bad);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      last_q   <= PORT1;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      if (any_gnt) last_q <= sel;
      rvalid_q <= {rsp && sel, rsp && !sel};
      err_q    <= {rsp && addr_bad && sel, rsp && addr_bad && !sel};
      if (rsp && !sel) rdata0_q <= addr_bad ? '0 : dm_WB;
      if (rsp &&  sel) rdata1_q <= addr_bad ? '0 : dm_WB;
    end
  end

  assign bus.gnt_0    = gnt_v[0];
  assign bus.gnt_1    = gnt_v[1];
  assign bus.rvalid_0 = rvalid_q[0];
  assign bus.rvalid_1 = rvalid_q[1];
  assign bus.err_0    = err_q[0];
  assign bus.err_1    = err_q[1];
  assign bus.rdata_0  = rdata0_q;
  assign bus.rdata_1  = rdata1_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomised and directed bench for dm_port_arbiter against a transaction-level reference model.
module tb_dm_port_arbiter;
  localparam int HOLD_MAX = 4;
  localparam int DM_WORDS = 3072;
`ifdef DM_ARB_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.DATA_W(32)) bus ();
  logic [31:0] dm_add, dm_data, dm_pc, dm_WB;
  logic        dm_memW, dm_memR;

  dm_port_arbiter #(.DATA_W(32), .DM_WORDS(DM_WORDS), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .dm_add  (dm_add),
    .dm_data (dm_data),
    .dm_memW (dm_memW),
    .dm_memR (dm_memR),
    .dm_pc   (dm_pc),
    .dm_WB   (dm_WB)
  );

  // data memory behind the arbiter
  logic [31:0] dm_mem [4096];
  assign dm_WB = dm_mem[dm_add[13:2]];
  always @(posedge clk) if (dm_memW) dm_mem[dm_add[13:2]] <= dm_data;

  // requester drive
  logic        rq [2];
  logic        wq [2];
  logic        lk [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] pcv [2];
  assign bus.req_0 = rq[0];   assign bus.req_1 = rq[1];
  assign bus.we_0 = wq[0];    assign bus.we_1 = wq[1];
  assign bus.lock_0 = lk[0];  assign bus.lock_1 = lk[1];
  assign bus.addr_0 = ad[0];  assign bus.addr_1 = ad[1];
  assign bus.wdata_0 = wd[0]; assign bus.wdata_1 = wd[1];
  assign bus.pc_0 = pcv[0];   assign bus.pc_1 = pcv[1];

  // reference model state
  int          m_owner, m_hold, m_last;
  logic [31:0] ref_mem [4096];
  bit          exp_rv [2];
  bit          exp_err [2];
  logic [31:0] exp_rd [2];
  int          last_g, obs_g;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return CHK_EN && ((a[1:0] != 2'b00) || (a[31:2] >= 30'(DM_WORDS)));
  endfunction

  function automatic int pick();
    int o;
    if (m_owner < 0) begin
      if (rq[0] && rq[1]) return 1 - m_last;
      if (rq[0]) return 0;
      if (rq[1]) return 1;
      return -1;
    end
    o = m_owner;
    if (rq[o] && (lk[o] || !rq[1-o] || m_hold < HOLD_MAX)) return o;
    if (lk[o]) return -1;
    if (rq[1-o]) return 1 - o;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_last = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'h0;
    end
  endtask

  task automatic setp(input int p, input bit r, input bit w, input bit l,
                      input logic [31:0] a, input logic [31:0] d);
    rq[p] = r; wq[p] = w; lk[p] = l; ad[p] = a; wd[p] = d; pcv[p] = $urandom;
  endtask

  task automatic idle_all();
    setp(0, 0, 0, 0, 32'h0, 32'h0);
    setp(1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // one clock: entered at a negedge with inputs settled, returns at the next negedge
  task automatic cycle();
    int g;
    bit bad;
    int idx;
    #1;
    g = reset ? pick() : -1;
    if (bus.gnt_0 && bus.gnt_1) obs_g = 2;
    else if (bus.gnt_1)         obs_g = 1;
    else if (bus.gnt_0)         obs_g = 0;
    else                        obs_g = -1;
    chk("gnt_0", bus.gnt_0, g == 0);
    chk("gnt_1", bus.gnt_1, g == 1);
    if (g >= 0) begin
      bad = is_bad(ad[g]);
      chk("dm_add", dm_add, ad[g]);
      chk("dm_data", dm_data, wd[g]);
      chk("dm_pc", dm_pc, pcv[g]);
      chk("dm_memW", dm_memW, wq[g] && !bad);
      chk("dm_memR", dm_memR, !wq[g] && !bad);
    end else begin
      chk("dm_add_idle", dm_add, 32'h0);
      chk("dm_data_idle", dm_data, 32'h0);
      chk("dm_memW_idle", dm_memW, 1'b0);
      chk("dm_memR_idle", dm_memR, 1'b0);
    end
    chk("rvalid_0", bus.rvalid_0, exp_rv[0]);
    chk("rvalid_1", bus.rvalid_1, exp_rv[1]);
    chk("rdata_0", bus.rdata_0, exp_rd[0]);
    chk("rdata_1", bus.rdata_1, exp_rd[1]);
    chk("err_0", bus.err_0, exp_err[0]);
    chk("err_1", bus.err_1, exp_err[1]);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (g >= 0) begin
      bad = is_bad(ad[g]);
      idx = int'(ad[g][13:2]);
      if (!wq[g] || bad) begin
        exp_rv[g] = 1'b1; exp_err[g] = bad; exp_rd[g] = bad ? 32'h0 : ref_mem[idx];
      end else begin
        exp_rv[g] = 1'b0; exp_err[g] = 1'b0;
      end
      exp_rv[1-g] = 1'b0; exp_err[1-g] = 1'b0;
      if (wq[g] && !bad) ref_mem[idx] = wd[g];
      m_hold  = (g == m_owner) ? ((m_hold < HOLD_MAX) ? m_hold + 1 : HOLD_MAX) : 1;
      m_owner = g;
      m_last  = g;
    end else begin
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
      if (m_owner >= 0 && !lk[m_owner]) begin
        m_owner = -1; m_hold = 0;
      end
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 4096; i++) begin
      dm_mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    idle_all();
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b1;

    // store then load through port 0
    setp(0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF); cycle();
    chk("t1_store_gnt", obs_g, 0);
    setp(0, 1, 0, 0, 32'h10, 32'h0); cycle();
    idle_all(); cycle();
    chk("t1_rdata", bus.rdata_0, 32'hDEAD_BEEF);
    cycle();

    // both ports loading continuously from reset
    reset = 1'b0; cycle(); reset = 1'b1;
    setp(0, 1, 0, 0, 32'h40, 32'h0);
    setp(1, 1, 0, 0, 32'h44, 32'h0);
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("t2_order", obs_g, t2[k]);
    end
    idle_all(); cycle(); cycle();

    // lock keeps port 0 beyond the hold limit
    setp(0, 1, 0, 1, 32'h50, 32'h0); cycle();
    setp(1, 1, 0, 0, 32'h54, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_lock", obs_g, 0);
    end
    setp(0, 0, 0, 0, 32'h0, 32'h0); cycle();
    chk("t3_handoff", obs_g, 1);
    setp(1, 0, 0, 1, 32'h54, 32'h0);
    setp(0, 1, 0, 0, 32'h58, 32'h0); cycle();
    chk("t3_blocked", obs_g, -1);
    setp(1, 0, 0, 0, 32'h0, 32'h0); cycle();
    chk("t3_release", obs_g, 0);
    idle_all(); cycle(); cycle();

    // port 0 load followed by port 1 store
    setp(0, 1, 0, 0, 32'h10, 32'h0); cycle();
    setp(0, 0, 0, 0, 32'h0, 32'h0);
    setp(1, 1, 1, 0, 32'h14, 32'h1234_5678); cycle();
    chk("t6_gnt1", obs_g, 1);
    idle_all(); cycle(); cycle();

    // misaligned and out-of-range addresses
    setp(0, 1, 0, 0, 32'h3002, 32'h0); cycle();
    setp(0, 1, 0, 0, 32'h3000, 32'h0); cycle();
    setp(0, 0, 0, 0, 32'h0, 32'h0);
    setp(1, 1, 1, 0, 32'h0000_4004, 32'hAAAA_5555); cycle();
    idle_all(); cycle(); cycle();

    // reset during a store drops it
    setp(1, 1, 1, 0, 32'h20, 32'h5);
    reset = 1'b0; cycle(); reset = 1'b1;
    idle_all(); cycle();
    setp(1, 1, 0, 0, 32'h20, 32'h0); cycle();
    idle_all(); cycle();
    chk("t4_no_commit", bus.rdata_1, 32'h0);
    cycle();

    // randomised traffic
    for (int n = 0; n < 700; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 99) < 45) begin
          logic [31:0] a;
          a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          if ($urandom_range(0, 99) < 6) a = $urandom_range(0, 1) ? (32'h3000 + $urandom_range(0, 64)) : {$urandom} | 32'h1;
          setp(p, 1, $urandom_range(0, 1), $urandom_range(0, 99) < 15, a, $urandom);
        end
      end
      reset = ($urandom_range(0, 199) != 0);
      cycle();
      if (!reset) idle_all();
      else if (last_g >= 0) setp(last_g, 0, 0, 0, 32'h0, 32'h0);
      reset = 1'b1;
    end
    idle_all(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
